// File: rtl/keycode_pkg.sv
// keycode_pkg: shared types and constants for the key report encoder.
// Holds the FSM state enum, slot/action counts, the fixed action-to-keycode
// map (P1 left/right/attack/jump, P2 left/right/attack/jump) and HID sentinels.
package keycode_pkg;
    typedef enum logic [1:0] {IDLE, UPDATE, SEND} state_e;
    localparam int NUM_SLOTS = 6;
    localparam int NUM_ACTIONS = 8;
    localparam logic [7:0] KEY_NONE = 8'h00;
    localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;
    localparam logic [7:0] P1_LEFT = 8'h04;
    localparam logic [7:0] P1_RIGHT = 8'h07;
    localparam logic [7:0] P1_ATTACK = 8'h1A;
    localparam logic [7:0] P1_JUMP = 8'h16;
    localparam logic [7:0] P2_LEFT = 8'h80;
    localparam logic [7:0] P2_RIGHT = 8'h79;
    localparam logic [7:0] P2_ATTACK = 8'h82;
    localparam logic [7:0] P2_JUMP = 8'h81;
    function automatic logic [7:0] act_code(input logic [2:0] idx);
        case (idx)
            3'd0: act_code = P1_LEFT;
            3'd1: act_code = P1_RIGHT;
            3'd2: act_code = P1_ATTACK;
            3'd3: act_code = P1_JUMP;
            3'd4: act_code = P2_LEFT;
            3'd5: act_code = P2_RIGHT;
            3'd6: act_code = P2_ATTACK;
            default: act_code = P2_JUMP;
        endcase
    endfunction
endpackage

// File: rtl/keyslot_alloc.sv
// keyslot_alloc: combinational slot-table search.
// Ports: slots (six packed 8-bit slots, slot k at [8k+7:8k]), code (keycode to
// look up); free_idx/full (lowest empty slot, no empty slot), match_idx/match
// (slot holding code, code present).
module keyslot_alloc
    import keycode_pkg::*;
(
    input  logic [NUM_SLOTS*8-1:0] slots,
    input  logic [7:0]             code,
    output logic [2:0]             free_idx,
    output logic                   full,
    output logic [2:0]             match_idx,
    output logic                   match
);
    // Scan downwards so the lowest-numbered hit is the one left standing.
    always_comb begin
        free_idx = '0;
        full = 1'b1;
        match_idx = '0;
        match = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slots[8*i +: 8] == KEY_NONE) begin
                free_idx = 3'(i);
                full = 1'b0;
            end
            if (slots[8*i +: 8] == code) begin
                match_idx = 3'(i);
                match = 1'b1;
            end
        end
    end
endmodule

// File: rtl/keyreport_encoder.sv
// keyreport_encoder: turns eight held action requests into a six-slot HID report.
// Ports: clk, reset_n (async active-low), act_req[7:0] (level-held requests),
// report_ready (sink accept); keycodes[47:0] (slot k at [8k+7:8k]),
// report_valid (report offered), overflow (more than six actions held).
// Define KEYREPORT_ROLLOVER_ERR_EN to send all-0x01 (ErrorRollOver) on overflow.
module keyreport_encoder
    import keycode_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  act_req,
    input  logic        report_ready,
    output logic [47:0] keycodes,
    output logic        report_valid,
    output logic        overflow
);
    state_e state_q, state_d;
    logic [7:0] snap_q, snap_d, held_q, held_d, prev_q, prev_d;
    logic [2:0] idx_q, idx_d;
    logic [47:0] slots_q, slots_d, keycodes_q, keycodes_d;
    logic overflow_q, overflow_d;
    logic [7:0] cur_code;
    logic [2:0] free_idx, match_idx;
    logic full, match, capture, press_now, release_now;

    keyslot_alloc u_alloc (
        .slots(slots_q),
        .code(cur_code),
        .free_idx(free_idx),
        .full(full),
        .match_idx(match_idx),
        .match(match)
    );

    // prev_q keeps the mask from before the capture so each action can be
    // classified as press/release; a dropped action simply never matches a slot.
    assign cur_code = act_code(idx_q);
    assign capture = (state_q == IDLE) && (act_req != held_q);
    assign press_now = snap_q[idx_q] && !prev_q[idx_q];
    assign release_now = !snap_q[idx_q] && prev_q[idx_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            snap_q <= '0;
            held_q <= '0;
            prev_q <= '0;
            idx_q <= '0;
            slots_q <= '0;
            keycodes_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q <= snap_d;
            held_q <= held_d;
            prev_q <= prev_d;
            idx_q <= idx_d;
            slots_q <= slots_d;
            keycodes_q <= keycodes_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = capture ? UPDATE : IDLE;
            UPDATE: state_d = (idx_q == 3'd7) ? SEND : UPDATE;
            SEND: state_d = report_ready ? IDLE : SEND;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        snap_d = snap_q;
        held_d = held_q;
        prev_d = prev_q;
        idx_d = idx_q;
        slots_d = slots_q;
        keycodes_d = keycodes_q;
        overflow_d = overflow_q;
        if (capture) begin
            snap_d = act_req;
            held_d = act_req;
            prev_d = held_q;
            idx_d = '0;
            overflow_d = $countones(act_req) > NUM_SLOTS;
        end
        if (state_q == UPDATE) begin
            idx_d = idx_q + 3'd1;
            if (release_now && match) slots_d[8*match_idx +: 8] = KEY_NONE;
            if (press_now && !full) slots_d[8*free_idx +: 8] = cur_code;
            // Latch the finished table as the report on the last update step.
            if (idx_q == 3'd7) begin
`ifdef KEYREPORT_ROLLOVER_ERR_EN
                keycodes_d = overflow_q ? {NUM_SLOTS{KEY_ERR_ROLLOVER}} : slots_d;
`else
                keycodes_d = slots_d;
`endif
            end
        end
    end

    always_comb begin
        report_valid = (state_q == SEND);
        keycodes = keycodes_q;
        overflow = overflow_q;
    end
endmodule

// File: tb/tb_keyreport_encoder.sv
// tb_keyreport_encoder: scoreboard bench for keyreport_encoder.
module tb_keyreport_encoder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic report_ready = 1'b1;
    logic [7:0] act_req = 8'h00;
    logic [47:0] keycodes;
    logic report_valid, overflow;
    int tests = 0;
    int fails = 0;
    logic [48:0] exp_q[$];

`ifdef KEYREPORT_ROLLOVER_ERR_EN
    localparam logic [47:0] FULL_RPT = 48'h010101010101;
`else
    localparam logic [47:0] FULL_RPT = 48'h7980161A0704;
`endif

    keyreport_encoder dut (
        .clk(clk),
        .reset_n(reset_n),
        .act_req(act_req),
        .report_ready(report_ready),
        .keycodes(keycodes),
        .report_valid(report_valid),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && report_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_report: got keycodes %h, want no report", keycodes);
            end else begin
                check("keycodes", keycodes, exp_q[0][47:0]);
                check("overflow", 48'(overflow), 48'(exp_q[0][48]));
                if (report_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic wait_report(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!report_valid && n < 100);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        check("drained", 48'(exp_q.size()), 48'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] a, input logic [47:0] kc, input logic ov);
        int n;
        exp_q.push_back({ov, kc});
        @(posedge clk);
        #1 act_req = a;
        wait_report(n);
        check("latency", 48'(n), 48'd9);
        drain();
    endtask

    initial begin
        int n;
        int stall_valid;
        #12;
        check("rst_keycodes", keycodes, 48'h0);
        check("rst_valid", 48'(report_valid), 48'd0);
        check("rst_overflow", 48'(overflow), 48'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_report", 48'(report_valid), 48'd0);
        send(8'h01, 48'h000000000004, 1'b0);
        send(8'h11, 48'h000000008004, 1'b0);
        send(8'h10, 48'h000000008000, 1'b0);
        send(8'h00, 48'h000000000000, 1'b0);
        send(8'hFF, FULL_RPT, 1'b1);
        send(8'h7F, FULL_RPT, 1'b1);
        send(8'h3F, 48'h7980161A0704, 1'b0);
        send(8'h3E, 48'h7980161A0700, 1'b0);
        send(8'h7E, 48'h7980161A0782, 1'b0);
        report_ready = 1'b0;
        exp_q.push_back({1'b0, 48'h0});
        @(posedge clk);
        #1 act_req = 8'h00;
        wait_report(n);
        check("stall_latency", 48'(n), 48'd9);
        stall_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 act_req = i[0] ? 8'h01 : 8'h02;
            @(negedge clk);
            stall_valid += int'(report_valid);
        end
        check("stall_valid_cycles", 48'(stall_valid), 48'd20);
        exp_q.push_back({1'b0, 48'h000000000004});
        @(posedge clk);
        #1 report_ready = 1'b1;
        drain();
        repeat (15) @(posedge clk);
        @(posedge clk);
        #1 act_req = 8'h02;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_keycodes", keycodes, 48'h0);
        check("midrst_valid", 48'(report_valid), 48'd0);
        check("midrst_overflow", 48'(overflow), 48'd0);
        exp_q.push_back({1'b0, 48'h000000000007});
        @(negedge clk);
        reset_n = 1'b1;
        wait_report(n);
        check("post_rst_latency", 48'(n), 48'd9);
        drain();
        repeat (10) @(posedge clk);
        check("queue_empty", 48'(exp_q.size()), 48'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
